// File: rtl/pmt_ctrl_pkg.sv
// pmt_ctrl_pkg: shared state encoding, default widths and scrub constants for the PMT controller
package pmt_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ALLOC, SCRUB, DONE} pmt_state_e;
  localparam int DEF_LMT_ID_WIDTH = 8;
  localparam int DEF_PMT_ID_WIDTH = 6;
  localparam logic SCRUB_DATA = 1'b0;
  localparam logic SCRUB_MASK = 1'b0;
endpackage

// File: rtl/pmt_free_finder.sv
// pmt_free_finder: lowest-index zero finder over the PMT used flags
module pmt_free_finder #(
  parameter int N  = 32,
  parameter int IW = 5
) (
  input  logic [N-1:0]  used,
  output logic          found,
  output logic [IW-1:0] idx
);
  // scan from the top down so the lowest free index is the last one written
  always_comb begin
    found = ~&used;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = used[i] ? idx : IW'(i);
  end
endmodule

// File: rtl/pmt_alloc_ctrl.sv
// pmt_alloc_ctrl: grants free PMTs to LMTs and scrubs released PMTs before returning them to the pool
module pmt_alloc_ctrl
  import pmt_ctrl_pkg::*;
#(
  parameter int NUM_PMTS     = 32,
  parameter int PMT_ID_WIDTH = DEF_PMT_ID_WIDTH,
  parameter int ADDR_WIDTH   = 5,
  parameter int DEPTH        = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int LMT_ID_WIDTH = DEF_LMT_ID_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             alloc_req,
  input  logic [LMT_ID_WIDTH-1:0]          alloc_lmt_id,
  output logic                             alloc_done,
  output logic                             alloc_fail,
  output logic [PMT_ID_WIDTH-1:0]          alloc_pmt_id,
  input  logic                             free_req,
  input  logic [PMT_ID_WIDTH-1:0]          free_pmt_id,
  output logic                             free_done,
  output logic                             free_err,
  output logic                             busy,
  output logic [PMT_ID_WIDTH-1:0]          free_count,
  output logic [NUM_PMTS-1:0]              pmt_used,
  output logic [NUM_PMTS*LMT_ID_WIDTH-1:0] pmt_lmt_id,
  output logic                             wr_en,
  output logic [PMT_ID_WIDTH-1:0]          wr_pmt_id,
  output logic [ADDR_WIDTH-1:0]            wr_addr,
  output logic [DATA_WIDTH-1:0]            wr_data,
  output logic [DATA_WIDTH-1:0]            wr_mask
);
  localparam int IW = $clog2(NUM_PMTS);
  pmt_state_e r_state;
  logic w_found;
  logic [IW-1:0] w_idx;
  logic w_free_ok;
  logic [IW-1:0] w_scrub_idx;

  pmt_free_finder #(.N(NUM_PMTS), .IW(IW)) u_finder (
    .used (pmt_used),
    .found(w_found),
    .idx  (w_idx)
  );

  assign w_free_ok = (free_pmt_id < PMT_ID_WIDTH'(NUM_PMTS)) && pmt_used[free_pmt_id[IW-1:0]];
  assign w_scrub_idx = wr_pmt_id[IW-1:0];
  assign busy = r_state != IDLE;
  assign wr_data = {DATA_WIDTH{SCRUB_DATA}};
  assign wr_mask = {DATA_WIDTH{SCRUB_MASK}};

  // FSM: accept in IDLE (free beats alloc), one-cycle grant, DEPTH-cycle scrub, one-cycle DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      pmt_used <= '0;
      pmt_lmt_id <= '0;
      free_count <= PMT_ID_WIDTH'(NUM_PMTS);
      alloc_done <= 1'b0;
      alloc_fail <= 1'b0;
      alloc_pmt_id <= '0;
      free_done <= 1'b0;
      free_err <= 1'b0;
      wr_en <= 1'b0;
      wr_pmt_id <= '0;
      wr_addr <= '0;
    end else begin
      alloc_done <= 1'b0;
      alloc_fail <= 1'b0;
      free_done <= 1'b0;
      free_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (free_req && w_free_ok) begin
            r_state <= SCRUB;
            wr_en <= 1'b1;
            wr_pmt_id <= free_pmt_id;
            wr_addr <= '0;
          end else if (free_req) begin
            r_state <= DONE;
            free_done <= 1'b1;
            free_err <= 1'b1;
          end else if (alloc_req) begin
            r_state <= ALLOC;
            alloc_done <= 1'b1;
            alloc_fail <= ~w_found;
            alloc_pmt_id <= w_found ? PMT_ID_WIDTH'(w_idx) : '0;
            if (w_found) begin
              pmt_used[w_idx] <= 1'b1;
              pmt_lmt_id[w_idx*LMT_ID_WIDTH +: LMT_ID_WIDTH] <= alloc_lmt_id;
              free_count <= free_count - PMT_ID_WIDTH'(1);
            end
          end
        end
        ALLOC: r_state <= DONE;
        SCRUB: begin
          if (wr_addr == ADDR_WIDTH'(DEPTH - 1)) begin
            r_state <= DONE;
            wr_en <= 1'b0;
            wr_addr <= '0;
            pmt_used[w_scrub_idx] <= 1'b0;
            pmt_lmt_id[w_scrub_idx*LMT_ID_WIDTH +: LMT_ID_WIDTH] <= '0;
            free_count <= free_count + PMT_ID_WIDTH'(1);
            free_done <= 1'b1;
          end else begin
            wr_addr <= wr_addr + ADDR_WIDTH'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/pmt_alloc_ctrl.md
Name: pmt_alloc_ctrl

Overview:
Allocation and reclaim controller for the PMT pool.
- Owns the per-PMT configuration vectors that drive the pool: used flags and owning LMT IDs.
- Grants free PMTs to logical match tables (LMTs) on request.
- On free, scrubs every entry of the released PMT through the pool's shared write port, then returns the PMT to the free set.
- Sits between the control-plane table manager and the PMT pool.

Parameters:
- NUM_PMTS, 32: number of PMTs managed.
- PMT_ID_WIDTH, 6: PMT ID width; must be at least clog2(NUM_PMTS)+1.
- ADDR_WIDTH, 5: PMT entry address width.
- DEPTH, 32: entries per PMT (scrub length).
- DATA_WIDTH, 32: PMT entry width.
- LMT_ID_WIDTH, 8: owner ID width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- alloc_req  in  1  allocation request; level, held until alloc_done.
- alloc_lmt_id  in  LMT_ID_WIDTH  requesting LMT; stable while alloc_req is high.
- alloc_done  out  1  one-cycle completion pulse.
- alloc_fail  out  1  qualifies alloc_done: no free PMT.
- alloc_pmt_id  out  PMT_ID_WIDTH  granted PMT; valid with alloc_done.
- free_req  in  1  free request; level, held until free_done.
- free_pmt_id  in  PMT_ID_WIDTH  PMT to release; stable while free_req is high.
- free_done  out  1  one-cycle completion pulse.
- free_err  out  1  qualifies free_done: illegal ID or PMT not in use.
- busy  out  1  high whenever the FSM is not in IDLE.
- free_count  out  PMT_ID_WIDTH  number of unused PMTs.
- pmt_used  out  NUM_PMTS  per-PMT allocated flags, to the pool.
- pmt_lmt_id  out  NUM_PMTS*LMT_ID_WIDTH  owner per PMT, packed as PMT i at [i*LMT_ID_WIDTH +: LMT_ID_WIDTH].
- wr_en  out  1  pool write enable (scrub).
- wr_pmt_id  out  PMT_ID_WIDTH  pool write target.
- wr_addr  out  ADDR_WIDTH  pool write address.
- wr_data  out  DATA_WIDTH  scrub data, always 0.
- wr_mask  out  DATA_WIDTH  scrub mask, always 0.

Behaviour:
- Reset values (all outputs registered):
  - pmt_used=0, pmt_lmt_id=0, free_count=NUM_PMTS.
  - alloc_done, alloc_fail, free_done, free_err, wr_en, busy = 0.
  - alloc_pmt_id=0, wr_pmt_id=0, wr_addr=0.
- FSM states: IDLE, ALLOC, SCRUB, DONE.
- IDLE: requests are sampled only here.
  - If free_req and alloc_req are both high, free_req wins; alloc_req stays pending.
- Free request with free_pmt_id >= NUM_PMTS or pmt_used[id]=0:
  - Moves to DONE; free_done=1 and free_err=1 in the next cycle.
  - No writes; no table change.
- Legal free request: moves to SCRUB and latches the ID.
  - wr_en=1 for exactly DEPTH consecutive cycles, starting the cycle after acceptance.
  - wr_pmt_id = latched ID; wr_addr = 0..DEPTH-1 ascending.
  - pmt_used[id] stays 1 throughout, because the pool gates writes with used.
  - On the edge after the last write: pmt_used[id] cleared, pmt_lmt_id[id] set to 0, free_count incremented, free_done pulses.
  - Latency: accept at cycle N, writes N+1..N+DEPTH, free_done at N+DEPTH+1.
- ALLOC (from IDLE on alloc_req): one cycle.
  - Selects the lowest-index PMT with pmt_used=0.
  - Sets used and owner, decrements free_count, pulses alloc_done with alloc_pmt_id.
  - Latency: accept at N, alloc_done at N+1, tables updated in the same cycle.
  - No free PMT: alloc_done=1, alloc_fail=1, alloc_pmt_id=0, no table change.
- DONE: one cycle, then IDLE.
  - The requester drops its request on the done pulse, so a request is never re-accepted.
  - A new request is accepted no earlier than the cycle after DONE.
- Done/fail/err outputs are single-cycle pulses and are 0 otherwise.
- Counter rule: free_count always equals the number of zeros in pmt_used; it never wraps.
- Reset mid-scrub or mid-alloc:
  - Next cycle wr_en=0, FSM in IDLE, all tables at reset values.
  - Partially scrubbed PMT contents are undefined, but the PMT is marked free.
- Requests seen while busy are ignored until IDLE; there is no queueing.

Decomposition:
- Shared package pmt_ctrl_pkg:
  - State enum.
  - LMT_ID_WIDTH and PMT_ID_WIDTH defaults.
  - Scrub constants: SCRUB_DATA=0, SCRUB_MASK=0.
- One sub-module, pmt_free_finder: combinational lowest-zero priority encoder over pmt_used, outputting found and index.

Test Plan:
1. Reset, then alloc_req with lmt_id=0x05 -> alloc_done at N+1, alloc_pmt_id=0, pmt_used[0]=1, pmt_lmt_id[0]=0x05, free_count=31.
2. Allocate 32 times, then a 33rd request -> 33rd gives alloc_done with alloc_fail=1, alloc_pmt_id=0, free_count=0, pmt_used all ones.
3. With PMT 3 in use, free_pmt_id=3 -> wr_en high for 32 cycles, addr 0..31, wr_pmt_id=3, data and mask 0; free_done at N+33; pmt_used[3]=0; free_count incremented.
4. Free of an unused PMT 7 and of ID 40 -> each gives free_done with free_err=1 at N+1, no wr_en, tables unchanged.
5. alloc_req and free_req asserted in the same cycle -> free is scrubbed first; alloc is granted after free_done plus DONE, receiving the just-freed lowest index.
6. rst asserted at scrub address 10 -> wr_en=0 the next cycle, all pmt_used=0, free_count=32, busy=0.
